// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder. One full-adder cell processes one bit per
// clock, LSB first, so a WIDTH-bit add takes WIDTH clocks in RUN plus one
// cycle in DONE.
// Optional build macro: SERIAL_ADDER_OVF_EN adds the 'ovf' output, a signed
// overflow flag.

// sc2_block: single-bit full adder. This is the only adder cell in the design.
module sc2_block (
  output logic s,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign s     = a ^ b ^ cin;
  assign c_out = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // The counter must be able to hold the value WIDTH, because it still
  // increments on the last RUN edge.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           load, step, last;
  logic           fa_s, fa_c;

  sc2_block u_fa (
    .s     (fa_s),
    .c_out (fa_c),
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. DONE always returns to IDLE, so start cannot be queued.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs and datapath controls decoded from the current state.
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
    load = (state == S_IDLE) && start;
    step = (state == S_RUN);
    last = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
  end

  // Datapath. Operands shift right into the adder, and each sum bit enters at
  // the MSB, so after WIDTH steps the sum register holds the result in order.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (step) begin
      a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + 1'b1;
      sum   <= {fa_s, sum[WIDTH-1:1]};
      if (last) cout <= fa_c;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: on the MSB step, the carry into the MSB differs from the
  // carry out of it.
  always_ff @(posedge clk) begin
    if (reset || load) ovf <= 1'b0;
    else if (last)     ovf <= carry ^ fa_c;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder at WIDTH=8.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, cin;
  logic [W-1:0] a, b, sum;
  logic         cout, busy, done;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one addition and follows it through RUN and DONE back to IDLE.
  task automatic run_add(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic [W-1:0] esum, input logic ecout);
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = ~vb; cin = ~vc;
    for (int k = 0; k < W; k++) begin
      chk({tag, " busy/done in RUN"}, {30'd0, busy, done}, 32'b10);
      tick();
    end
    chk({tag, " busy/done in DONE"}, {30'd0, busy, done}, 32'b01);
    chk({tag, " sum"}, 32'(sum), 32'(esum));
    chk({tag, " cout"}, 32'(cout), 32'(ecout));
    tick();
    chk({tag, " idle after DONE"}, {30'd0, busy, done}, 32'b00);
    chk({tag, " sum held"}, {23'd0, cout, sum}, {23'd0, ecout, esum});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rexp;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    chk("reset state", {22'd0, busy, done, cout, sum}, 32'd0);

    // Release reset on the same edge as start: start is accepted there.
    reset = 1'b0;
    run_add("0f+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("0f+01 ovf", 32'(ovf), 32'd0);
`endif
    run_add("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_add("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_add("7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("7f+01 ovf", 32'(ovf), 32'd1);
`endif
    run_add("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("80+80 ovf", 32'(ovf), 32'd1);
`endif
    run_add("10+20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("10+20 ovf", 32'(ovf), 32'd0);
`endif
    run_add("00+00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Idle hold: no start, so the outputs keep their values.
    tick(); tick();
    chk("idle hold", {22'd0, busy, done, cout, sum}, 32'd0);

    // A start pulse during RUN edge 3 must be ignored.
    a = 8'h21; b = 8'h13; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 4; k <= W; k++) begin
      chk("mid-start no early done", 32'(done), 32'd0);
      tick();
    end
    chk("mid-start done", {30'd0, busy, done}, 32'b01);
    chk("mid-start sum", {23'd0, cout, sum}, 32'h034);
    tick();
    chk("mid-start single done", {30'd0, busy, done}, 32'b00);
    tick();
    chk("mid-start not requeued", {30'd0, busy, done}, 32'b00);

    // Reset at RUN edge 4 abandons the addition without a done pulse.
    a = 8'h55; b = 8'hAA; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort state", {22'd0, busy, done, cout, sum}, 32'd0);
    for (int k = 0; k < W + 2; k++) begin
      chk("abort no done", {30'd0, busy, done}, 32'b00);
      tick();
    end
    run_add("after abort", 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0);

    // Back-to-back with start held high: period is W+2 edges.
    start = 1'b1;
    for (int n = 0; n < 256; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      a = ra; b = rb; cin = rc;
      rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      tick();
      chk("b2b accepted", 32'(busy), 32'd1);
      a = ~ra; b = ~rb;
      for (int k = 0; k < W; k++) tick();
      chk("b2b done", {30'd0, busy, done}, 32'b01);
      chk("b2b result", {23'd0, cout, sum}, {23'd0, rexp});
      tick();
      chk("b2b idle", {30'd0, busy, done}, 32'b00);
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
